// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Purpose
//   This block is the write side of the instruction memory. It takes a byte
//   stream from the boot/debug source and packs each group of four bytes into
//   one 32-bit word, little-endian. The word is then written to the next word
//   address, starting at 0. The CPU fetch side waits until done pulses.
//
// Ports
//   clk            in   1       rising-edge clock
//   rst            in   1       synchronous, active-high reset
//   start          in   1       begin a load (only looked at in IDLE)
//   length         in   11      number of words to load, sampled with start
//   in_valid       in   1       byte source has data
//   in_data        in   8       byte from the source
//   in_ready       out  1       a byte is accepted this cycle if in_valid
//   mem_we         out  1       one-cycle write strobe to the memory
//   write_address  out  ADDR_W  word index, zero-extended
//   write_data     out  32      assembled instruction word
//   busy           out  1       high in RECV and WRITE
//   done           out  1       one-cycle pulse at end of load
//   err            out  1       length > DEPTH, held until next good start
//   checksum       out  32      XOR of all written words (optional)
//
// Optional feature
//   Define IMEM_LOADER_CHECKSUM_EN to build the running XOR checksum.
//   If it is not defined, checksum is tied to zero.
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [10:0]       length,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] write_address,
    output logic [31:0]       write_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    localparam int CNT_W = 11;
    // One extra bit so a length of up to 2047 can be compared with DEPTH
    // without any truncation.
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [CNT_W-1:0]   length_reg;
    logic [CNT_W-1:0]   word_cnt_reg;
    logic [CNT_W-1:0]   word_cnt_next;
    logic [1:0]         byte_cnt_reg;
    logic [7:0]         lane_reg [3];     // bytes 0..2 of the word being built
    logic [31:0]        write_data_reg;
    logic [CNT_W-1:0]   write_addr_reg;
    logic               err_reg;

    logic               start_take;
    logic               len_zero;
    logic               len_over;
    logic               accept;
    logic               last_byte;

    assign start_take    = (state_reg == IDLE) && start;
    assign len_zero      = (length == '0);
    assign len_over      = ({1'b0, length} > DEPTH_L);
    assign accept        = (state_reg == RECV) && in_valid;
    assign last_byte     = accept && (byte_cnt_reg == 2'd3);
    assign word_cnt_next = word_cnt_reg + CNT_W'(1);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    // A zero-length or oversize request skips RECV entirely.
                    // This way, no write can ever reach past the store.
                    if (len_zero || len_over) begin
                        state_next = DONE;
                    end else begin
                        state_next = RECV;
                    end
                end
            end
            RECV: begin
                if (last_byte) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (word_cnt_next == length_reg) begin
                    state_next = DONE;
                end else begin
                    state_next = RECV;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control counters, length latch and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            length_reg   <= '0;
            word_cnt_reg <= '0;
            byte_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (start_take) begin
                if (len_over) begin
                    err_reg <= 1'b1;
                end else if (!len_zero) begin
                    err_reg      <= 1'b0;
                    length_reg   <= length;
                    word_cnt_reg <= '0;
                    byte_cnt_reg <= '0;
                end
            end
            if (accept) begin
                // A 2-bit counter wraps 3 -> 0 on the fourth byte.
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
            if (state_reg == WRITE) begin
                word_cnt_reg <= word_cnt_next;
                byte_cnt_reg <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte lanes 0..2. Byte 3 never needs storing, because it goes
    // straight into write_data together with the three stored lanes.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg[gi] <= '0;
                end else if (accept && (byte_cnt_reg == 2'(gi))) begin
                    lane_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write port registers. They are loaded as the FSM enters WRITE, so
    // they are valid in the mem_we cycle. They then keep that value
    // through DONE and IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            write_data_reg <= '0;
            write_addr_reg <= '0;
        end else if (last_byte) begin
            write_data_reg <= {in_data, lane_reg[2], lane_reg[1], lane_reg[0]};
            write_addr_reg <= word_cnt_reg;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_reg;

    // The XOR is folded in at the end of each WRITE cycle. This makes the
    // final value visible in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_reg <= '0;
        end else if (start_take) begin
            checksum_reg <= '0;
        end else if (state_reg == WRITE) begin
            checksum_reg <= checksum_reg ^ write_data_reg;
        end
    end

    assign checksum = checksum_reg;
`else
    assign checksum = 32'h0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready      = (state_reg == RECV);
    assign mem_we        = (state_reg == WRITE);
    assign busy          = (state_reg == RECV) || (state_reg == WRITE);
    assign done          = (state_reg == DONE);
    assign err           = err_reg;
    assign write_data    = write_data_reg;
    assign write_address = {{(ADDR_W - CNT_W){1'b0}}, write_addr_reg};

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. It runs directed loads and random
// loads. Expected words and checksums come from the byte lists, packed
// little-endian with plain arithmetic. The monitor logs every write and
// every handshake the DUT makes.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] length;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [63:0] write_address;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] checksum;

    int checks   = 0;
    int failures = 0;

    imem_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .length        (length),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .write_address (write_address),
        .write_data    (write_data),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .checksum      (checksum)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Monitor. It samples on the falling edge and only appends to logs,
    // so the main sequence works from snapshots.
    // ------------------------------------------------------------------
    logic [63:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_lat_q[$];
    int          cyc          = 0;
    int          last_hs_cyc  = 0;
    int          hs_total     = 0;
    int          done_total   = 0;
    int          busy_total   = 0;
    int          ready_in_we  = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) begin
            hs_total    <= hs_total + 1;
            last_hs_cyc <= cyc;
        end
        if (mem_we) begin
            wr_addr_q.push_back(write_address);
            wr_data_q.push_back(write_data);
            wr_lat_q.push_back(cyc - last_hs_cyc);
            if (in_ready) ready_in_we <= ready_in_we + 1;
        end
        if (done) done_total <= done_total + 1;
        if (busy) busy_total <= busy_total + 1;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [10:0] len);
        start  = 1'b1;
        length = len;
        tick();
        start  = 1'b0;
    endtask

    // Drives one byte, waiting up to 40 cycles for it to be accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    // Waits for done and leaves the bench parked at that falling edge.
    task automatic wait_done(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    function automatic logic [31:0] exp_checksum(input logic [31:0] x);
`ifdef IMEM_LOADER_CHECKSUM_EN
        return x;
`else
        return 32'h0 & x;
`endif
    endfunction

    // Runs a full load from a byte list. It then checks every write,
    // the checksum, and that done pulsed once.
    task automatic run_load(input string tag, input logic [7:0] bytes[$], input int max_gap);
        int          n_words;
        int          wbase;
        int          dbase;
        logic [31:0] w;
        logic [31:0] xs;
        n_words = bytes.size() / 4;
        wbase   = wr_data_q.size();
        dbase   = done_total;
        start_load(11'(n_words));
        foreach (bytes[i]) send_byte(bytes[i], int'($urandom_range(0, max_gap)));
        wait_done({tag, "_done"});
        xs = 32'h0;
        for (int k = 0; k < n_words; k++) begin
            w = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
            xs ^= w;
        end
        check({tag, "_checksum"}, 64'(checksum), 64'(exp_checksum(xs)));
        check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        tick();
        tick();
        check({tag, "_write_count"}, 64'(wr_data_q.size() - wbase), 64'(n_words));
        check({tag, "_done_pulses"}, 64'(done_total - dbase), 64'd1);
        for (int k = 0; k < n_words && (wbase + k) < wr_data_q.size(); k++) begin
            w = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
            check($sformatf("%s_addr%0d", tag, k), wr_addr_q[wbase+k], 64'(k));
            check($sformatf("%s_data%0d", tag, k), 64'(wr_data_q[wbase+k]), 64'(w));
            check($sformatf("%s_lat%0d", tag, k), 64'(wr_lat_q[wbase+k]), 64'd1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_mem_we"},   64'(mem_we),   64'd0);
        check({tag, "_addr"},     write_address, 64'd0);
        check({tag, "_data"},     64'(write_data), 64'd0);
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_done"},     64'(done),     64'd0);
        check({tag, "_err"},      64'(err),      64'd0);
        check({tag, "_checksum"}, 64'(checksum), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed and random sequence
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] bl[$];
        logic [7:0] pat_bytes[4];
        bit         pat_valid[7];
        int         wbase;
        int         dbase;
        int         bbase;
        int         hbase;
        int         bi;

        rst      = 1'b1;
        start    = 1'b0;
        length   = '0;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Two-word reference program
        bl = '{8'h03, 8'h2A, 8'h05, 8'h00, 8'hB3, 8'h0A, 8'h40, 8'h01};
        run_load("two_words", bl, 0);
        check("two_words_word0", 64'(wr_data_q[wr_data_q.size()-2]), 64'h00052A03);
        check("two_words_word1", 64'(wr_data_q[wr_data_q.size()-1]), 64'h01400AB3);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("two_words_checksum_abs", 64'(checksum), 64'h014520B0);
`endif

        // length == 0: straight to DONE, nothing written, never busy
        wbase = wr_data_q.size();
        bbase = busy_total;
        dbase = done_total;
        start_load(11'd0);
        @(negedge clk);
        check("len0_done", 64'(done), 64'd1);
        check("len0_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("len0_done_one_cycle", 64'(done), 64'd0);
        tick();
        check("len0_no_write", 64'(wr_data_q.size() - wbase), 64'd0);
        check("len0_busy_cycles", 64'(busy_total - bbase), 64'd0);
        check("len0_done_pulses", 64'(done_total - dbase), 64'd1);

        // Oversize length sets err, pulses done, writes nothing
        wbase = wr_data_q.size();
        dbase = done_total;
        start_load(11'd1025);
        @(negedge clk);
        check("over_err", 64'(err), 64'd1);
        check("over_done", 64'(done), 64'd1);
        repeat (3) tick();
        check("over_err_held", 64'(err), 64'd1);
        check("over_no_write", 64'(wr_data_q.size() - wbase), 64'd0);
        check("over_done_pulses", 64'(done_total - dbase), 64'd1);

        // The next good start clears err
        start_load(11'd1);
        check("err_cleared", 64'(err), 64'd0);
        send_byte(8'h5A, 0);
        send_byte(8'h6B, 0);
        send_byte(8'h7C, 0);
        send_byte(8'h8D, 0);
        wait_done("len1_done");
        check("len1_data", 64'(wr_data_q[wr_data_q.size()-1]), 64'h8D7C6B5A);
        tick();

        // Backpressure: in_valid follows a fixed per-cycle pattern
        pat_valid = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        pat_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        wbase = wr_data_q.size();
        hbase = hs_total;
        bbase = ready_in_we;
        start_load(11'd1);
        bi = 0;
        for (int c = 0; c < 7; c++) begin
            in_valid = pat_valid[c];
            in_data  = pat_bytes[bi];
            @(negedge clk);
            if (in_valid && in_ready && bi < 3) bi++;
            tick();
        end
        in_valid = 1'b0;
        wait_done("bp_done");
        tick();
        check("bp_handshakes", 64'(hs_total - hbase), 64'd4);
        check("bp_write_count", 64'(wr_data_q.size() - wbase), 64'd1);
        check("bp_data", 64'(wr_data_q[wr_data_q.size()-1]), 64'h44332211);
        check("bp_ready_in_write", 64'(ready_in_we - bbase), 64'd0);

        // Reset partway through a word. The partial word must never
        // be written.
        wbase = wr_data_q.size();
        start_load(11'd1);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        tick();
        check("midrst_no_write", 64'(wr_data_q.size() - wbase), 64'd0);
        bl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load("after_rst", bl, 1);
        check("after_rst_data", 64'(wr_data_q[wr_data_q.size()-1]), 64'hDDCCBBAA);

        // A start pulse while busy must be ignored
        wbase = wr_data_q.size();
        dbase = done_total;
        start_load(11'd2);
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        start  = 1'b1;
        length = 11'd5;
        tick();
        start  = 1'b0;
        send_byte(8'h30, 0);
        send_byte(8'h40, 0);
        send_byte(8'h50, 0);
        send_byte(8'h60, 0);
        send_byte(8'h70, 0);
        send_byte(8'h80, 0);
        wait_done("restart_done");
        repeat (2) tick();
        check("restart_write_count", 64'(wr_data_q.size() - wbase), 64'd2);
        check("restart_done_pulses", 64'(done_total - dbase), 64'd1);
        check("restart_word1_addr", wr_addr_q[wr_addr_q.size()-1], 64'd1);
        check("restart_word1", 64'(wr_data_q[wr_data_q.size()-1]), 64'h80706050);

        // Random loads
        for (int t = 0; t < 6; t++) begin
            int nw;
            nw = int'($urandom_range(1, 5));
            bl = {};
            for (int k = 0; k < 4 * nw; k++) bl.push_back(8'($urandom));
            run_load($sformatf("rand%0d", t), bl, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit to make sure the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
